// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
package mips_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] line_t;

    // Bubble instruction: sll $0,$0,0
    localparam word_t NOP_WORD   = 32'h0000_0000;
    localparam word_t RESET_PC   = 32'h0000_0000;
    localparam word_t PC_INCR    = 32'd4;
    localparam int    LINE_WORDS = 4;

endpackage : mips_pkg

// File: rtl/ins_fetch_word_sel.sv
// Combinational selection of one 32-bit word out of an I-cache line.
module ins_fetch_word_sel #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic [32*LINE_WORDS-1:0] line_in,
    input  logic [IDX_W-1:0]         word_idx,
    output logic [31:0]              word_out
);

    // Word k occupies bits [32k+31:32k] of the line.
    always_comb begin
        word_out = line_in[32*word_idx +: 32];
    end

endmodule : ins_fetch_word_sel

// File: rtl/ins_fetch.sv
// MIPS instruction-fetch stage: program counter, word selection from the
// current I-cache line, and the IF/ID output registers.
// Optional build macro INSFETCH_LINE_BUF_EN adds a one-line buffer that
// serves misses on the most recently hit line.
import mips_pkg::*;

module ins_fetch #(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD,
    parameter int          LINE_WORDS = mips_pkg::LINE_WORDS
) (
    input  logic                     clk,
    input  logic                     rstn,          // active-high, synchronous
    input  logic                     iSIG_PCSrc,
    input  logic [32*LINE_WORDS-1:0] imem_in,
    input  logic [31:0]              iaddr4branch,
    input  logic                     icacheHit,
    output logic [31:0]              obranch_adder,
    output logic [31:0]              oins
);

    localparam int IDX_W   = $clog2(LINE_WORDS);
    localparam int TAG_LSB = 2 + IDX_W;

    word_t pc_q, pc_d;
    word_t ins_q, ins_d;
    word_t badd_q, badd_d;

    logic [32*LINE_WORDS-1:0] fetch_line;
    logic                     fetch_ok;
    word_t                    fetch_word;

`ifdef INSFETCH_LINE_BUF_EN
    logic [32*LINE_WORDS-1:0] buf_line_q, buf_line_d;
    logic [31:TAG_LSB]        buf_tag_q, buf_tag_d;
    logic                     buf_valid_q, buf_valid_d;

    // Choose the live cache line on a hit, the buffered line when it matches.
    always_comb begin
        fetch_ok    = icacheHit ||
                      (buf_valid_q && (buf_tag_q == pc_q[31:TAG_LSB]));
        fetch_line  = icacheHit ? imem_in : buf_line_q;
        buf_line_d  = icacheHit ? imem_in : buf_line_q;
        buf_tag_d   = icacheHit ? pc_q[31:TAG_LSB] : buf_tag_q;
        buf_valid_d = buf_valid_q | icacheHit;
    end

    // Line buffer registers; only the valid bit needs a reset value.
    // NOTE: buffer data and tag are left unreset on purpose -- the valid bit
    // alone guarantees they are never used before the first load.
    always_ff @(posedge clk) begin
        if (rstn) begin
            buf_valid_q <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
        end
        buf_line_q <= buf_line_d;
        buf_tag_q  <= buf_tag_d;
    end
`else
    // Without a buffer the only source of instructions is the cache line.
    always_comb begin
        fetch_ok   = icacheHit;
        fetch_line = imem_in;
    end
`endif

    ins_fetch_word_sel #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_word_sel (
        .line_in  (fetch_line),
        .word_idx (pc_q[2 +: IDX_W]),
        .word_out (fetch_word)
    );

    // Next-state logic for PC and the IF/ID outputs; a redirect overrides a stall.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        pc_d   = pc_q;
        ins_d  = NOP_WORD;
        badd_d = badd_q;
        if (fetch_ok) begin
            ins_d  = fetch_word;
            badd_d = pc_q + PC_INCR;
            pc_d   = pc_q + PC_INCR;
        end
        if (iSIG_PCSrc) begin
            pc_d = iaddr4branch & ~32'd3;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // from pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rstn) begin
            pc_q   <= RESET_PC;
            ins_q  <= NOP_WORD;
            badd_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ins_q  <= ins_d;
            badd_q <= badd_d;
        end
    end

    assign oins          = ins_q;
    assign obranch_adder = badd_q;

endmodule : ins_fetch

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch rules.
module tb_ins_fetch;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         pcsrc = 1'b0;
    logic [127:0] imem = '0;
    logic [31:0]  tgt = '0;
    logic         hit = 1'b0;
    logic [31:0]  obranch_adder;
    logic [31:0]  oins;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Behavioural model state
    logic [31:0]  ref_pc, ref_ins, ref_badd;
    logic [127:0] ref_buf;
    logic [31:0]  ref_buf_tag;
    logic         ref_buf_valid;

    ins_fetch dut (
        .clk           (clk),
        .rstn          (rstn),
        .iSIG_PCSrc    (pcsrc),
        .imem_in       (imem),
        .iaddr4branch  (tgt),
        .icacheHit     (hit),
        .obranch_adder (obranch_adder),
        .oins          (oins)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_word(input logic [127:0] line, input logic [31:0] pc);
        logic [127:0] shifted;
        int           k;
        k       = (pc / 4) % 4;
        shifted = line >> (32 * k);
        return shifted[31:0];
    endfunction

    // Advance the model by one clock edge using the spec's rules.
    task automatic model_step(input logic r, input logic s, input logic [31:0] t,
                              input logic [127:0] l, input logic h);
        logic         served;
        logic [127:0] src_line;
        if (r) begin
            ref_pc        = 32'h0;
            ref_ins       = 32'h0;
            ref_badd      = 32'h0;
            ref_buf_valid = 1'b0;
            return;
        end
        served   = h;
        src_line = l;
`ifdef INSFETCH_LINE_BUF_EN
        if (!h && ref_buf_valid && (ref_buf_tag == (ref_pc >> 4))) begin
            served   = 1'b1;
            src_line = ref_buf;
        end
`endif
        if (h) begin
            ref_buf       = l;
            ref_buf_tag   = ref_pc >> 4;
            ref_buf_valid = 1'b1;
        end
        if (served) begin
            ref_ins  = pick_word(src_line, ref_pc);
            ref_badd = ref_pc + 32'd4;
        end else begin
            ref_ins = 32'h0;
        end
        if (s)           ref_pc = {t[31:2], 2'b00};
        else if (served) ref_pc = ref_pc + 32'd4;
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after rising edge.
    task automatic cyc(input logic r, input logic s, input logic [31:0] t,
                       input logic [127:0] l, input logic h);
        @(negedge clk);
        rstn  = r;
        pcsrc = s;
        tgt   = t;
        imem  = l;
        hit   = h;
        @(posedge clk);
        model_step(r, s, t, l, h);
        #1;
        check("oins", oins, ref_ins);
        check("obranch_adder", obranch_adder, ref_badd);
    endtask

    logic [127:0] line_abcd, line_90, line_88, line_1234, line_wrap, line_r;

    initial begin
        ref_pc = '0; ref_ins = '0; ref_badd = '0;
        ref_buf = '0; ref_buf_tag = '0; ref_buf_valid = 1'b0;

        line_abcd = {32'hD, 32'hC, 32'hB, 32'hA};
        line_90   = {4{32'h90}};
        line_88   = {32'h8803, 32'h88, 32'h8801, 32'h8800};
        line_1234 = {32'h4444, 32'h3333, 32'h2222, 32'h1234};
        line_wrap = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

        // Reset, then stream A..D
        cyc(1, 0, 0, line_abcd, 1);
        check("reset_oins", oins, 32'h0);
        check("reset_badd", obranch_adder, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, line_abcd, 1);
            check("stream_oins", oins, 32'hA + i);
            check("stream_badd", obranch_adder, 4 * (i + 1));
        end

        // Self-branch at PC 0
        cyc(1, 0, 0, line_90, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 32'h0, line_90, 1);
            check("selfbr_oins", oins, 32'h90);
            check("selfbr_badd", obranch_adder, 32'h4);
        end

        // Miss stall at PC 8
        cyc(1, 0, 0, line_88, 0);
        cyc(0, 0, 0, line_88, 1);
        cyc(0, 0, 0, line_88, 1);
        check("pre_stall_badd", obranch_adder, 32'h8);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, line_88, 0);
`ifndef INSFETCH_LINE_BUF_EN
            check("stall_oins", oins, 32'h0);
            check("stall_badd", obranch_adder, 32'h8);
`endif
        end
`ifndef INSFETCH_LINE_BUF_EN
        cyc(0, 0, 0, line_88, 1);
        check("unstall_oins", oins, 32'h88);
        check("unstall_badd", obranch_adder, 32'hC);
`endif

        // Redirect during miss
        cyc(0, 1, 32'h40, line_88, 0);
        cyc(0, 0, 0, line_1234, 1);
        check("redir_oins", oins, 32'h1234);
        check("redir_badd", obranch_adder, 32'h44);

        // Wrap and alignment
        cyc(0, 1, 32'hFFFF_FFFF, line_1234, 1);
        cyc(0, 0, 0, line_wrap, 1);
        check("wrap_oins", oins, 32'hCAFE_0003);
        check("wrap_badd", obranch_adder, 32'h0);
        cyc(0, 0, 0, line_wrap, 1);
        check("wrap_next_oins", oins, 32'hCAFE_0000);
        check("wrap_next_badd", obranch_adder, 32'h4);

        // Reset mid-stream during hit + redirect
        cyc(1, 1, 32'h100, line_wrap, 1);
        check("midrst_oins", oins, 32'h0);
        check("midrst_badd", obranch_adder, 32'h0);
        cyc(0, 0, 0, line_abcd, 1);
        check("midrst_pc_oins", oins, 32'hA);
        check("midrst_pc_badd", obranch_adder, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        r, s, h;
            logic [31:0] t;
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 6) == 0);
            h = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       t = ref_pc;
                1:       t = $urandom_range(0, 255);
                default: t = $urandom;
            endcase
            line_r = {$urandom, $urandom, $urandom, $urandom};
            cyc(r, s, t, line_r, h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_ins_fetch
